// File: rtl/demodulate_2fsk.sv
// 2FSK demodulator: measures the period of a 1-bit square wave, classifies it as
// the short or long tone, and debounces the decision into a recovered data bit.
module demodulate_2fsk #(
    parameter int   CNT_W         = 16,
    parameter int   PERIOD_THRESH = 8,
    parameter logic SHORT_SYM     = 1'b1,
    parameter int   CONFIRM       = 2,
    parameter int   TIMEOUT       = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Data_in,
    output logic             Data_out,
    output logic             locked,
    output logic             sym_change,
    output logic [CNT_W-1:0] period
);

    localparam int               RUN_W     = (CONFIRM < 1) ? 1 : $clog2(CONFIRM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_V  = CNT_W'(PERIOD_THRESH);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] CONFIRM_V = RUN_W'(CONFIRM);

    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             cand;
    logic             cls;
    logic             armed;
    logic             timeout_hit;

    assign rise = s2 & ~s3;

    // The edge that closes a period is counted as part of it, so a saturated
    // counter must not wrap when that closing edge is added.
    always_comb begin
        meas        = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
        cls         = (meas <= THRESH_V) ? SHORT_SYM : ~SHORT_SYM;
        run_next    = RUN_W'(1);
        if (cls == cand) begin
            run_next = (run == RUN_MAX) ? run : run + RUN_W'(1);
        end
        // Fires on the edge that moves the counter onto TIMEOUT.
        timeout_hit = armed & ~rise & (cnt == TO_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            run        <= '0;
            cand       <= 1'b0;
            armed      <= 1'b0;
            Data_out   <= 1'b0;
            locked     <= 1'b0;
            sym_change <= 1'b0;
            period     <= '0;
        end else begin
            s1         <= Data_in;
            s2         <= s1;
            s3         <= s2;
            sym_change <= 1'b0;

            if (rise) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (rise) begin
                if (armed) begin
                    period <= meas;
                    cand   <= cls;
                    run    <= run_next;
                    if (run_next >= CONFIRM_V) begin
                        locked <= 1'b1;
                        if (cls != Data_out) begin
                            Data_out   <= cls;
                            sym_change <= 1'b1;
                        end
                    end
                end else begin
                    // First edge after reset or carrier loss only starts timing.
                    armed <= 1'b1;
                end
            end else if (timeout_hit) begin
                locked <= 1'b0;
                armed  <= 1'b0;
                run    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_demodulate_2fsk.sv
// Directed testbench for demodulate_2fsk: drives square waves of known period
// and compares the recovered outputs against hand-derived values.
module tb_demodulate_2fsk;

    logic        clk;
    logic        reset;
    logic        Data_in;
    logic        Data_out;
    logic        locked;
    logic        sym_change;
    logic [15:0] period;

    int checks   = 0;
    int failures = 0;
    int sym_count = 0;

    demodulate_2fsk dut (
        .clk        (clk),
        .reset      (reset),
        .Data_in    (Data_in),
        .Data_out   (Data_out),
        .locked     (locked),
        .sym_change (sym_change),
        .period     (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock of stimulus: sample outputs settled from the last posedge,
    // then set Data_in for the coming posedge.
    task automatic apply_stimulus(input logic value);
        @(negedge clk);
        if (sym_change === 1'b1) sym_count++;
        Data_in = value;
    endtask

    task automatic drive_period(input int hi, input int lo);
        repeat (hi) apply_stimulus(1'b1);
        repeat (lo) apply_stimulus(1'b0);
    endtask

    // Period-6 lock from a fresh reset, checking the exact edge of the update.
    task automatic lock_short_exact(input string tag);
        sym_count = 0;
        drive_period(3, 3);
        drive_period(3, 3);
        apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        check_output({tag, "_locked_edge1"}, 32'(locked), 32'd0);
        check_output({tag, "_data_edge1"}, 32'(Data_out), 32'd0);
        apply_stimulus(1'b0);
        check_output({tag, "_locked_edge2"}, 32'(locked), 32'd1);
        check_output({tag, "_data_edge2"}, 32'(Data_out), 32'd1);
        check_output({tag, "_symchg_edge2"}, 32'(sym_change), 32'd1);
        check_output({tag, "_period_edge2"}, 32'(period), 32'd6);
        apply_stimulus(1'b0);
        apply_stimulus(1'b0);
        repeat (7) drive_period(3, 3);
        check_output({tag, "_sym_pulses"}, 32'(sym_count), 32'd1);
        check_output({tag, "_data_end"}, 32'(Data_out), 32'd1);
        check_output({tag, "_period_end"}, 32'(period), 32'd6);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        Data_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        Data_in = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_data", 32'(Data_out), 32'd0);
        check_output("rst_locked", 32'(locked), 32'd0);
        check_output("rst_symchg", 32'(sym_change), 32'd0);
        check_output("rst_period", 32'(period), 32'd0);
        reset = 1'b1;

        lock_short_exact("s1");

        // Single long period among short ones is rejected by the debounce.
        sym_count = 0;
        repeat (3) drive_period(3, 3);
        drive_period(6, 6);
        drive_period(3, 3);
        check_output("glitch_period_long", 32'(period), 32'd12);
        check_output("glitch_data_mid", 32'(Data_out), 32'd1);
        repeat (3) drive_period(3, 3);
        check_output("glitch_data", 32'(Data_out), 32'd1);
        check_output("glitch_sym_pulses", 32'(sym_count), 32'd0);

        // Switch to the long tone: change only on the second long period.
        sym_count = 0;
        drive_period(6, 6);
        drive_period(6, 6);
        check_output("switch_data_first_long", 32'(Data_out), 32'd1);
        check_output("switch_period_first_long", 32'(period), 32'd12);
        drive_period(6, 6);
        check_output("switch_data_second_long", 32'(Data_out), 32'd0);
        check_output("switch_sym_pulses", 32'(sym_count), 32'd1);

        // Long tone from reset: locks at 0 without any symbol change.
        do_reset();
        sym_count = 0;
        repeat (10) drive_period(6, 6);
        check_output("long_locked", 32'(locked), 32'd1);
        check_output("long_data", 32'(Data_out), 32'd0);
        check_output("long_period", 32'(period), 32'd12);
        check_output("long_sym_pulses", 32'(sym_count), 32'd0);

        // Threshold boundary: 8 is short, 9 is long.
        do_reset();
        repeat (4) drive_period(4, 4);
        check_output("thr8_data", 32'(Data_out), 32'd1);
        check_output("thr8_period", 32'(period), 32'd8);
        repeat (4) drive_period(5, 4);
        check_output("thr9_data", 32'(Data_out), 32'd0);
        check_output("thr9_period", 32'(period), 32'd9);

        // Carrier loss: lock on short, then hold low until timeout.
        do_reset();
        repeat (4) drive_period(3, 3);
        check_output("to_locked_before", 32'(locked), 32'd1);
        sym_count = 0;
        drive_period(3, 3);
        repeat (1019) apply_stimulus(1'b0);
        apply_stimulus(1'b0);
        check_output("to_locked_at_1022", 32'(locked), 32'd1);
        apply_stimulus(1'b0);
        check_output("to_locked_at_1023", 32'(locked), 32'd0);
        check_output("to_data_hold", 32'(Data_out), 32'd1);
        drive_period(3, 3);
        drive_period(3, 3);
        check_output("to_relock_early", 32'(locked), 32'd0);
        drive_period(3, 3);
        check_output("to_relock", 32'(locked), 32'd1);
        check_output("to_relock_data", 32'(Data_out), 32'd1);
        check_output("to_sym_pulses", 32'(sym_count), 32'd0);

        // Asynchronous reset mid-stream, outputs clear without a clock edge.
        drive_period(3, 3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("arst_data", 32'(Data_out), 32'd0);
        check_output("arst_locked", 32'(locked), 32'd0);
        check_output("arst_period", 32'(period), 32'd0);
        check_output("arst_symchg", 32'(sym_change), 32'd0);
        Data_in = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        lock_short_exact("s6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/demodulate_2fsk.md
Name: demodulate_2fsk

Overview:
- Receive-side counterpart of the 2FSK modulator: recovers the binary data stream from a 1-bit square-wave 2FSK signal.
- Measures the period of the incoming waveform in clk cycles, classifies each period as the frequency_1 or frequency_2 tone, and debounces the decision before updating Data_out.
- Sits between the channel/loopback input and the downstream bit sink; flags loss of carrier.

Parameters:
- CNT_W, 16, width of the period counter; saturates at 2^CNT_W-1.
- PERIOD_THRESH, 8, periods <= PERIOD_THRESH clk cycles are SHORT, otherwise LONG.
- SHORT_SYM, 1, data value for a SHORT period; LONG maps to ~SHORT_SYM. Default: frequency_2 is the faster tone and encodes 1.
- CONFIRM, 2, number of consecutive equal classifications required before Data_out changes; must be >= 1.
- TIMEOUT, 1023, clk cycles without an input rising edge before carrier is declared lost; must be < 2^CNT_W-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- Data_in  input  1  received 2FSK square wave, asynchronous to clk
- Data_out  output  1  recovered data bit (registered)
- locked  output  1  high while a valid carrier is being tracked
- sym_change  output  1  one-cycle pulse on the cycle Data_out changes value
- period  output  CNT_W  last measured period, for debug

Behaviour:
- Reset (reset=0, asynchronous): Data_out=0, locked=0, sym_change=0, period=0. Synchronizer, counter, run count, candidate and armed flag are all cleared. Reset asserted mid-symbol aborts the measurement; after release the first edge is discarded.
- Sync/edge detect: Data_in passes through a 2-flop synchronizer s1,s2, then a delay flop s3. rise = s2 & ~s3.
- Counter cnt: cleared on a rise cycle, else cnt <= min(cnt+1, 2^CNT_W-1).
- On rise with armed=1:
  - P = cnt+1, so an input period of N clocks gives P=N.
  - period <= P.
  - cls = (P <= PERIOD_THRESH) ? SHORT_SYM : ~SHORT_SYM.
  - If cls == cand: run <= sat(run+1). Else: cand <= cls, run <= 1.
  - When the updated run >= CONFIRM: set locked <= 1; if cand differs from Data_out, then Data_out <= cand and sym_change=1 for that cycle.
- On rise with armed=0: armed <= 1 and no classification is made. This applies to the first edge after reset or after a timeout.
- Timeout: when armed=1 and cnt reaches TIMEOUT with no rise, then locked <= 0, armed <= 0, run <= 0. Data_out holds its last value. Timeout and rise in the same cycle: rise wins.
- Latency: let clk edge 0 be the first edge that samples Data_in=1. Data_out, locked, period and sym_change update at edge 2.
- Period exactly = PERIOD_THRESH classifies as SHORT.
- A saturated counter yields P = 2^CNT_W-1, which is LONG (unreachable unless TIMEOUT is misconfigured).
- Data_in glitches shorter than 1 clk may be missed; no further filtering is required.
- sym_change never asserts while locked transitions 0->1 unless Data_out actually changes.

Test Plan:
- Defaults; reset low, then a square wave with period 6 clk (3 high/3 low) for 10 periods -> first edge discarded; locked=1 and Data_out=1 at edge 2 after the 3rd rising input edge; period=6; sym_change pulses exactly once.
- Period 12 for 10 periods after reset -> locked=1, Data_out stays 0, period=12, no sym_change pulse.
- Lock on period 6, then switch to period 12 -> Data_out 1->0 on the 2nd long period; single sym_change pulse; a single 12-clk period inserted among 6-clk periods causes no change.
- Period exactly 8 vs. period 9 -> 8 classifies SHORT (1), 9 classifies LONG (0).
- Lock on period 6, then hold Data_in=0 -> locked falls exactly when cnt=1023; Data_out holds 1; on resumption the first edge is discarded and relock needs CONFIRM more edges.
- Assert reset mid-stream while Data_out=1 -> all outputs are 0 immediately, without waiting for clk; after release, relock follows the first scenario.
